nco_qw_pipelined: RTL and testbench

- Parametrised successor to the team's free-running NCO: phase accumulator, phase offset, quarter-wave sine table with symmetry folding, registered signed sin/cos outputs.
- Adds load-qualified increment update, phase sync (accumulator clear), programmable phase offset, and a true out_valid that reflects pipeline fill.
- Sits ahead of the SDR mixer / DDC; one instance per channel, driven by the ADC sample-rate clken.

---
 rtl/nco_qw_pipelined.sv | 143 ++++++++++++++
 tb/tb_nco_qw_pipelined.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/nco_qw_pipelined.sv
// nco_qw_pipelined
//   Numerically controlled oscillator with phase accumulator, phase offset,
//   a quarter-wave sine table with symmetry folding, and registered signed
//   sin/cos outputs. It has three pipeline stages, and all state advances
//   only on clken.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   clken         sample enable; every register holds when low
//   phi_inc_i     phase increment candidate
//   phi_inc_load  capture phi_inc_i into the increment register (with clken)
//   phase_ofs_i   phase offset added after the accumulator (sampled each clken)
//   phase_sync    clear accumulator and pipeline fill (with clken)
//   fsin_o        signed sine
//   fcos_o        signed cosine
//   out_valid     outputs correspond to a fully propagated sample

module nco_qw_pipelined #(
  parameter int unsigned ACCUMULATOR_WIDTH = 32,
  parameter int unsigned OUT_WIDTH         = 12,
  parameter int unsigned LUT_ADDR_WIDTH    = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clken,
  input  logic [ACCUMULATOR_WIDTH-1:0] phi_inc_i,
  input  logic                         phi_inc_load,
  input  logic [ACCUMULATOR_WIDTH-1:0] phase_ofs_i,
  input  logic                         phase_sync,
  output logic [OUT_WIDTH-1:0]         fsin_o,
  output logic [OUT_WIDTH-1:0]         fcos_o,
  output logic                         out_valid
);

  localparam int unsigned AW    = ACCUMULATOR_WIDTH;
  localparam int unsigned PW    = LUT_ADDR_WIDTH + 2;  // quadrant + table index
  localparam int unsigned MAG_W = OUT_WIDTH - 1;
  localparam int unsigned N     = 1 << LUT_ADDR_WIDTH;
  localparam real         TwoPi = 6.283185307179586;

  // Table entries sample the centre of each step, so no entry is exactly 0 or
  // full scale. This keeps the folded quadrants symmetric without special
  // cases.
  function automatic logic [MAG_W-1:0] lut_entry(input int k);
    real amp;
    real ang;
    amp = real'((1 << (OUT_WIDTH - 1)) - 1);
    ang = TwoPi * (real'(k) + 0.5) / real'(4 * N);
    return MAG_W'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [MAG_W-1:0] w_lut [N];

  for (genvar k = 0; k < N; k++) begin : g_lut
    assign w_lut[k] = lut_entry(k);
  end

  // Pipeline state
  logic [AW-1:0]          r_acc;
  logic [AW-1:0]          r_inc;
  logic [PW-1:0]          r_s1_phase;  // only the bits that address the table
  logic [MAG_W-1:0]       r_sin_mag;
  logic [MAG_W-1:0]       r_cos_mag;
  logic                   r_sin_neg;
  logic                   r_cos_neg;
  logic [OUT_WIDTH-1:0]   r_fsin;
  logic [OUT_WIDTH-1:0]   r_fcos;
  logic [1:0]             r_fill;
  logic                   r_out_valid;

  // Next-state / decode
  logic [AW-1:0]             w_acc_d;
  logic [AW-1:0]             w_inc_d;
  logic [PW-1:0]             w_s1_phase_d;
  logic [1:0]                w_q_sin;
  logic [1:0]                w_q_cos;
  logic [LUT_ADDR_WIDTH-1:0] w_idx;
  logic [LUT_ADDR_WIDTH-1:0] w_sin_addr;
  logic [LUT_ADDR_WIDTH-1:0] w_cos_addr;
  logic [1:0]                w_fill_d;

  always_comb begin
    w_acc_d      = phase_sync ? '0 : r_acc + r_inc;
    w_inc_d      = phi_inc_load ? phi_inc_i : r_inc;
    // S1 captures the pre-update accumulator, so a sync cycle still emits the
    // old phase. That sample is masked by the fill restart.
    w_s1_phase_d = PW'((r_acc + phase_ofs_i) >> (AW - PW));

    w_q_sin      = r_s1_phase[PW-1 -: 2];
    w_q_cos      = w_q_sin + 2'd1;  // cos(x) = sin(x + 90 deg)
    w_idx        = r_s1_phase[LUT_ADDR_WIDTH-1:0];
    // Odd quadrants run the quarter wave backwards.
    w_sin_addr   = w_q_sin[0] ? ~w_idx : w_idx;
    w_cos_addr   = w_q_cos[0] ? ~w_idx : w_idx;

    if (phase_sync) begin
      w_fill_d = 2'd0;
    end else if (r_fill == 2'd3) begin
      w_fill_d = 2'd3;
    end else begin
      w_fill_d = r_fill + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_inc       <= '0;
      r_s1_phase  <= '0;
      r_sin_mag   <= '0;
      r_cos_mag   <= '0;
      r_sin_neg   <= 1'b0;
      r_cos_neg   <= 1'b0;
      r_fsin      <= '0;
      r_fcos      <= '0;
      r_fill      <= 2'd0;
      r_out_valid <= 1'b0;
    end else if (clken) begin
      // Stage A
      r_acc       <= w_acc_d;
      r_inc       <= w_inc_d;
      r_s1_phase  <= w_s1_phase_d;
      // Stage B: synchronous table read
      r_sin_mag   <= w_lut[w_sin_addr];
      r_cos_mag   <= w_lut[w_cos_addr];
      r_sin_neg   <= w_q_sin[1];
      r_cos_neg   <= w_q_cos[1];
      // Stage C: apply sign; the magnitude is one bit narrower, so negation
      // cannot overflow.
      r_fsin      <= r_sin_neg ? -{1'b0, r_sin_mag} : {1'b0, r_sin_mag};
      r_fcos      <= r_cos_neg ? -{1'b0, r_cos_mag} : {1'b0, r_cos_mag};
      // out_valid is registered alongside fill, so it tracks fill == 3.
      r_fill      <= w_fill_d;
      r_out_valid <= (w_fill_d == 2'd3);
    end
  end

  assign fsin_o    = r_fsin;
  assign fcos_o    = r_fcos;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_nco_qw_pipelined.sv
// Directed testbench for nco_qw_pipelined with default parameters
// (32-bit accumulator, 12-bit outputs, 1024-entry quarter-wave table).

module tb_nco_qw_pipelined;

  logic        clk;
  logic        reset;
  logic        clken;
  logic [31:0] phi_inc_i;
  logic        phi_inc_load;
  logic [31:0] phase_ofs_i;
  logic        phase_sync;
  logic [11:0] fsin_o;
  logic [11:0] fcos_o;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  nco_qw_pipelined dut (
    .clk          (clk),
    .reset        (reset),
    .clken        (clken),
    .phi_inc_i    (phi_inc_i),
    .phi_inc_load (phi_inc_load),
    .phase_ofs_i  (phase_ofs_i),
    .phase_sync   (phase_sync),
    .fsin_o       (fsin_o),
    .fcos_o       (fcos_o),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge with the given enable; outputs are sampled 1 time unit later.
  task automatic tick(input logic en);
    clken = en;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int s, input int c, input int v);
    check({tag, ".sin"}, 32'($signed(fsin_o)), s);
    check({tag, ".cos"}, 32'($signed(fcos_o)), c);
    check({tag, ".valid"}, {31'd0, out_valid}, v);
  endtask

  task automatic check_valid(input string tag, input int v);
    check({tag, ".valid"}, {31'd0, out_valid}, v);
  endtask

  initial begin
    reset        = 1'b1;
    clken        = 1'b0;
    phi_inc_i    = '0;
    phi_inc_load = 1'b0;
    phase_ofs_i  = '0;
    phase_sync   = 1'b0;
    #12;
    check_out("reset", 0, 0, 0);
    reset = 1'b0;
    #1;

    // 90-degree steps: load inc and sync together so acc restarts from 0.
    phi_inc_i = 32'h4000_0000; phi_inc_load = 1'b1; phase_sync = 1'b1;
    tick(1'b1);
    phi_inc_load = 1'b0; phase_sync = 1'b0;
    check_valid("q_sync", 0);
    tick(1'b1); check_valid("q_fill1", 0);
    tick(1'b1); check_valid("q_fill2", 0);
    tick(1'b1); check_out("q_000", 2, 2047, 1);
    tick(1'b1); check_out("q_090", 2047, -2, 1);
    tick(1'b1); check_out("q_180", -2, -2047, 1);
    tick(1'b1); check_out("q_270", -2047, 2, 1);
    tick(1'b1); check_out("q_360", 2, 2047, 1);

    // clken gaps: outputs hold, enabled-cycle sequence continues unchanged.
    tick(1'b0); check_out("hold_a", 2, 2047, 1);
    tick(1'b1); check_out("en_090", 2047, -2, 1);
    tick(1'b0); check_out("hold_b", 2047, -2, 1);
    tick(1'b0); check_out("hold_c", 2047, -2, 1);
    tick(1'b1); check_out("en_180", -2, -2047, 1);

    // 180-degree offset takes effect after two more clken cycles.
    phase_ofs_i = 32'h8000_0000;
    tick(1'b1); check_out("ofs_pre270", -2047, 2, 1);
    tick(1'b1); check_out("ofs_pre000", 2, 2047, 1);
    tick(1'b1); check_out("ofs_090inv", -2047, 2, 1);
    tick(1'b1); check_out("ofs_180inv", 2, 2047, 1);

    // Asynchronous reset between edges clears outputs without a clock.
    #3;
    reset = 1'b1;
    #1;
    check_out("async_rst", 0, 0, 0);
    phase_ofs_i = '0;
    #2;
    reset = 1'b0;
    // inc_reg is 0 after reset: constant phase 0 once the pipeline fills.
    tick(1'b1); check_valid("rst_fill1", 0);
    tick(1'b1); check_valid("rst_fill2", 0);
    tick(1'b1); check_out("rst_c0", 2, 2047, 1);
    tick(1'b1); check_out("rst_c1", 2, 2047, 1);

    // inc = -1 LSB: wraps into the top quadrant.
    phi_inc_i = 32'hFFFF_FFFF; phi_inc_load = 1'b1; phase_sync = 1'b1;
    tick(1'b1);
    phi_inc_load = 1'b0; phase_sync = 1'b0;
    check_valid("wrap_sync", 0);
    tick(1'b1);
    tick(1'b1);
    tick(1'b1); check_out("wrap_0", 2, 2047, 1);
    tick(1'b1); check_out("wrap_m1", -2, 2047, 1);
    tick(1'b1); check_out("wrap_m2", -2, 2047, 1);

    // Back to 90-degree steps, then sync and load 45-degree steps together.
    phi_inc_i = 32'h4000_0000; phi_inc_load = 1'b1; phase_sync = 1'b1;
    tick(1'b1);
    phi_inc_load = 1'b0; phase_sync = 1'b0;
    tick(1'b1);
    tick(1'b1);
    tick(1'b1); check_out("r90_000", 2, 2047, 1);
    tick(1'b1); check_out("r90_090", 2047, -2, 1);
    phi_inc_i = 32'h2000_0000; phi_inc_load = 1'b1; phase_sync = 1'b1;
    tick(1'b1);
    phi_inc_load = 1'b0; phase_sync = 1'b0;
    check_valid("s45_drop0", 0);
    tick(1'b1); check_valid("s45_drop1", 0);
    tick(1'b1); check_valid("s45_drop2", 0);
    // sin(45 deg) reads entry 512, cos(45 deg) reads entry 511.
    tick(1'b1); check_out("s45_000", 2, 2047, 1);
    tick(1'b1); check_out("s45_045", 1449, 1446, 1);
    tick(1'b1); check_out("s45_090", 2047, -2, 1);
    tick(1'b1); check_out("s45_135", 1446, -1449, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
